inv_subbytes_iter: RTL and testbench

Iterative inverse SubBytes engine for the AES-256 decryption datapath; it undoes the encryption-side byte substitution.
- Accepts one 128-bit state on a valid/ready handshake.
- Substitutes LANES bytes per cycle through LANES inverse S-box instances.
- Presents the result on a second valid/ready handshake.
- Sits between the decryption round's InvShiftRows and AddRoundKey stages and trades latency for area.

---
 rtl/aes_pkg.sv | 37 +++
 rtl/inv_sbox.sv | 13 +
 rtl/inv_subbytes_iter.sv | 116 +++++++++++
 tb/tb_inv_subbytes_iter.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: block width, byte type, inverse S-box table, engine FSM states.
// Latency: none (package only).
// Backpressure: none (package only).
package aes_pkg;

   localparam int AES_BLK_W  = 128;
   localparam int AES_NBYTES = AES_BLK_W / 8;

   typedef logic [7:0] byte_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Inverse of the AES byte substitution, indexed by the substituted byte.
   localparam byte_t INV_SBOX [256] = '{
      8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
      8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
      8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
      8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
      8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
      8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
      8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
      8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
      8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
      8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
      8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
      8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
      8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
      8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
      8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
      8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
   };

endpackage

// File: rtl/inv_sbox.sv
// One-byte inverse S-box lookup.
// Latency: combinational, zero cycles.
// Backpressure: none, pure function of its input.
module inv_sbox
   import aes_pkg::*;
(
   input  logic [7:0] i_byte,
   output logic [7:0] o_byte
);

   assign o_byte = INV_SBOX[i_byte];

endmodule

// File: rtl/inv_subbytes_iter.sv
// Iterative inverse SubBytes: LANES bytes per cycle, MSB byte first, over a 128-bit state.
// Latency: 16/LANES cycles from input accept to out_valid; block period 16/LANES+1 cycles.
// Backpressure: result held in DONE until out_ready; in DONE a new block is accepted only with out_ready.
module inv_subbytes_iter
   import aes_pkg::*;
#(
   parameter int LANES = 4
)
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [AES_BLK_W-1:0] in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [AES_BLK_W-1:0] out_data,
   output logic                 busy
);

   localparam int NCHUNK = AES_NBYTES / LANES;
   localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
      $error("inv_subbytes_iter: LANES must be one of 1, 2, 4, 8, 16");
   end

   state_e               r_state;
   state_e               w_state_nxt;
   logic [CW-1:0]        r_cnt;
   logic [CW-1:0]        w_cnt_nxt;
   logic [AES_BLK_W-1:0] r_work;
   logic [AES_BLK_W-1:0] w_work_nxt;
   logic                 r_busy;
   logic [7:0]           w_lane_in  [LANES];
   logic [7:0]           w_lane_out [LANES];

   // Select the chunk addressed by the counter; byte 0 sits at the top of the word.
   always_comb begin
      for (int l = 0; l < LANES; l++) begin
         w_lane_in[l] = r_work[AES_BLK_W-1 - 8*(int'(r_cnt)*LANES + l) -: 8];
      end
   end

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      inv_sbox u_inv_sbox (
         .i_byte (w_lane_in[g]),
         .o_byte (w_lane_out[g])
      );
   end

   // Next-state, handshake outputs and work-register update.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_work_nxt  = r_work;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      case (r_state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               w_work_nxt  = in_data;
               w_cnt_nxt   = '0;
               w_state_nxt = RUN;
            end
         end
         RUN: begin
            for (int l = 0; l < LANES; l++) begin
               w_work_nxt[AES_BLK_W-1 - 8*(int'(r_cnt)*LANES + l) -: 8] = w_lane_out[l];
            end
            if (r_cnt == CW'(NCHUNK - 1)) begin
               w_cnt_nxt   = '0;
               w_state_nxt = DONE;
            end else begin
               w_cnt_nxt   = r_cnt + CW'(1);
            end
         end
         DONE: begin
            out_valid = 1'b1;
            // Accepting alongside the output handshake removes the IDLE bubble.
            in_ready  = out_ready;
            if (out_ready) begin
               w_state_nxt = IDLE;
               if (in_valid) begin
                  w_work_nxt  = in_data;
                  w_cnt_nxt   = '0;
                  w_state_nxt = RUN;
               end
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // State, counter, work register and busy flag, with synchronous reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_work  <= '0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_work  <= w_work_nxt;
         r_busy  <= (w_state_nxt != IDLE);
      end
   end

   assign out_data = r_work;
   assign busy     = r_busy;

endmodule

// File: tb/tb_inv_subbytes_iter.sv
// Bench for inv_subbytes_iter: one instance per legal LANES value, GF(2^8)-derived S-box model.
// Latency: n/a.
// Backpressure: exercised by holding out_ready low in DONE.
module tb_inv_subbytes_iter;

   localparam int NI = 5;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid  [NI];
   logic         in_ready  [NI];
   logic [127:0] in_data   [NI];
   logic         out_valid [NI];
   logic         out_ready [NI];
   logic [127:0] out_data  [NI];
   logic         busy      [NI];

   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      inv_subbytes_iter #(.LANES(1 << g)) u_dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .in_valid  (in_valid[g]),
         .in_ready  (in_ready[g]),
         .in_data   (in_data[g]),
         .out_valid (out_valid[g]),
         .out_ready (out_ready[g]),
         .out_data  (out_data[g]),
         .busy      (busy[g])
      );
   end

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   int last_acc = 0;
   int last_out = 0;

   logic [7:0] fwd  [256];
   logic [7:0] invm [256];

   task automatic check(input string name, input int lanes, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s (LANES=%0d): got %h, expected %h", name, lanes, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      tests++;
      fails++;
      $display("FAIL %s: timed out waiting for DUT", name);
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, aa, bb;
      p = 8'h00; aa = a; bb = b;
      for (int i = 0; i < 8; i++) begin
         if (bb[0]) p = p ^ aa;
         aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
         bb = {1'b0, bb[7:1]};
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
      logic [15:0] w;
      w = {b, b} << n;
      return w[15:8];
   endfunction

   // S-box from its definition: multiplicative inverse in GF(2^8) then the affine map.
   task automatic build_model();
      logic [7:0] inv, s;
      for (int a = 0; a < 256; a++) begin
         inv = 8'h00;
         for (int b = 1; b < 256; b++) begin
            if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
         end
         s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
         fwd[a]  = s;
         invm[s] = 8'(a);
      end
   endtask

   function automatic logic [127:0] sub_blk(input logic [127:0] x, input bit inverse);
      logic [127:0] r;
      for (int i = 0; i < 16; i++) begin
         r[127 - 8*i -: 8] = inverse ? invm[x[127 - 8*i -: 8]] : fwd[x[127 - 8*i -: 8]];
      end
      return r;
   endfunction

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   // Model: each instance holds at most one block; it becomes visible NCHUNK edges after capture.
   logic         have  [NI] = '{default: 1'b0};
   logic [127:0] exp_d [NI];
   int           acc   [NI];

   initial begin
      logic eov, eir;
      forever begin
         @(negedge clk);
         for (int k = 0; k < NI; k++) begin
            if (cyc > 0) begin
               eov = have[k] && ((cyc - acc[k]) >= (16 >> k));
               eir = !have[k] || (eov && out_ready[k]);
               check("out_valid", 1 << k, {127'd0, out_valid[k]}, {127'd0, eov});
               check("busy",      1 << k, {127'd0, busy[k]},      {127'd0, have[k]});
               check("in_ready",  1 << k, {127'd0, in_ready[k]},  {127'd0, eir});
               if (eov) check("out_data", 1 << k, out_data[k], exp_d[k]);
               if (!rst_n) begin
                  have[k] = 1'b0;
               end else begin
                  if (eov && out_ready[k]) have[k] = 1'b0;
                  if (in_valid[k] && eir) begin
                     have[k]  = 1'b1;
                     exp_d[k] = sub_blk(in_data[k], 1'b1);
                     acc[k]   = cyc + 1;
                  end
               end
            end
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 just after the accepting edge.
   task automatic send(input int k, input logic [127:0] d);
      bit ok;
      ok = 1'b0;
      in_data[k]  = d;
      in_valid[k] = 1'b1;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         if (in_ready[k]) begin
            ok = 1'b1;
            last_acc = cyc + 1;
         end
      end
      if (!ok) timeout("send");
      @(posedge clk);
      #1;
      in_valid[k] = 1'b0;
   endtask

   task automatic recv(input int k, output logic [127:0] d);
      bit ok;
      ok = 1'b0;
      d  = '0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         if (out_valid[k] && out_ready[k]) begin
            ok = 1'b1;
            d  = out_data[k];
            last_out = cyc;
         end
      end
      if (!ok) timeout("recv");
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [127:0] got, xa, xb, xc;
      logic [127:0] xs [8];
      logic [127:0] gs [8];
      int           at [8];
      int           ni, no;
      bit           seen;

      rst_n = 1'b0;
      for (int k = 0; k < NI; k++) begin
         in_valid[k]  = 1'b0;
         in_data[k]   = '0;
         out_ready[k] = 1'b1;
      end
      build_model();
      check("model sbox[00]",  0, {120'd0, fwd[8'h00]},  128'h63);
      check("model sbox[01]",  0, {120'd0, fwd[8'h01]},  128'h7c);
      check("model sbox[53]",  0, {120'd0, fwd[8'h53]},  128'hed);
      check("model isbox[00]", 0, {120'd0, invm[8'h00]}, 128'h52);
      check("model isbox[ff]", 0, {120'd0, invm[8'hff]}, 128'h7d);

      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      for (int k = 0; k < NI; k++) begin
         check("reset out_data",  1 << k, out_data[k], 128'd0);
         check("reset out_valid", 1 << k, {127'd0, out_valid[k]}, 128'd0);
         check("reset busy",      1 << k, {127'd0, busy[k]}, 128'd0);
      end
      @(posedge clk);
      #1;

      // All-0x63 block inverts to zero in 4 cycles, valid for a single cycle.
      send(2, {16{8'h63}});
      recv(2, got);
      check("t1 data",    4, got, 128'd0);
      check("t1 latency", 4, 128'(last_out - last_acc), 128'd4);
      @(negedge clk);
      check("t1 one-cycle valid", 4, {127'd0, out_valid[2]}, 128'd0);
      @(posedge clk);
      #1;

      send(2, 128'h00_01_63_7c_ed_16_ff_00_00_00_00_00_00_00_00_00);
      recv(2, got);
      check("t2 data", 4, got, 128'h52_09_00_01_53_ff_7d_52_52_52_52_52_52_52_52_52);

      // Held result under backpressure, pending input accepted with the output handshake.
      xa = 128'h0011_2233_4455_6677_8899_aabb_ccdd_eeff;
      xb = 128'hdead_beef_0123_4567_89ab_cdef_f00d_cafe;
      out_ready[2] = 1'b0;
      send(2, sub_blk(xa, 1'b0));
      seen = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(negedge clk);
         seen = out_valid[2];
      end
      if (!seen) timeout("t4 valid");
      @(posedge clk);
      #1;
      in_data[2]  = sub_blk(xb, 1'b0);
      in_valid[2] = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("t4 hold valid",  4, {127'd0, out_valid[2]}, 128'd1);
         check("t4 hold data",   4, out_data[2], xa);
         check("t4 hold inrdy",  4, {127'd0, in_ready[2]}, 128'd0);
         @(posedge clk);
         #1;
      end
      out_ready[2] = 1'b1;
      @(negedge clk);
      check("t4 accept with output", 4, {126'd0, in_ready[2], out_valid[2]}, 128'd3);
      last_acc = cyc + 1;
      @(posedge clk);
      #1;
      in_valid[2] = 1'b0;
      recv(2, got);
      check("t4 second data",    4, got, xb);
      check("t4 second latency", 4, 128'(last_out - last_acc), 128'd4);

      // Continuous stream of 8 blocks.
      for (int j = 0; j < 8; j++) xs[j] = {$urandom, $urandom, $urandom, $urandom};
      ni = 0;
      no = 0;
      in_data[2]  = sub_blk(xs[0], 1'b0);
      in_valid[2] = 1'b1;
      for (int i = 0; i < 200 && no < 8; i++) begin
         @(negedge clk);
         if (out_valid[2] && out_ready[2]) begin
            gs[no] = out_data[2];
            no++;
         end
         if (in_valid[2] && in_ready[2]) begin
            at[ni] = cyc;
            ni++;
         end
         @(posedge clk);
         #1;
         if (ni < 8) in_data[2] = sub_blk(xs[ni], 1'b0);
         else        in_valid[2] = 1'b0;
      end
      if (no < 8) timeout("t5 stream");
      for (int j = 0; j < no; j++) check("t5 stream data", 4, gs[j], xs[j]);
      for (int j = 1; j < ni; j++) check("t5 accept period", 4, 128'(at[j] - at[j-1]), 128'd5);

      // Reset while the counter is at 2: block discarded, no output.
      xc = 128'h0f0e_0d0c_0b0a_0908_0706_0504_0302_0100;
      send(2, sub_blk(xc, 1'b0));
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("t6 out_valid", 4, {127'd0, out_valid[2]}, 128'd0);
      check("t6 busy",      4, {127'd0, busy[2]}, 128'd0);
      check("t6 out_data",  4, out_data[2], 128'd0);
      check("t6 in_ready",  4, {127'd0, in_ready[2]}, 128'd1);
      @(posedge clk);
      #1;
      repeat (20) @(posedge clk);
      #1;

      // Round trip for every lane count.
      for (int k = 0; k < NI; k++) begin
         for (int n = 0; n < 1000; n++) begin
            xa = {$urandom, $urandom, $urandom, $urandom};
            send(k, sub_blk(xa, 1'b0));
            recv(k, got);
            check("t3 round trip", 1 << k, got, xa);
            check("t3 latency",    1 << k, 128'(last_out - last_acc), 128'(16 >> k));
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
